// File: rtl/lstx_feed_pkg.sv
// Shared constants for the lstx feed path: FSM encodings and parameter defaults.
package lstx_feed_pkg;

   localparam int unsigned DMSB_DEF = 9;
   localparam int unsigned AMSB_DEF = 2;
   localparam int unsigned TMSB_DEF = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_WBUSY = 2'b01,
      ST_WDONE = 2'b10
   } st_e;

endpackage

// File: rtl/lstx_feed_if.sv
// Host write/status and transmitter handshake signals of the lstx feeder.
interface lstx_feed_if
   import lstx_feed_pkg::*;
#(
   parameter int unsigned DMSB = DMSB_DEF,
   parameter int unsigned AMSB = AMSB_DEF
);
   logic            wr;
   logic [DMSB:0]   wdata;
   logic            flush;
   logic            full;
   logic [AMSB+1:0] level;
   logic            ovf;
   logic            err;
   logic            tx_push;
   logic [DMSB:0]   tx_wdata;
   logic            tx_empty;
   st_e             st;

   modport slave (
      input  wr, wdata, flush, tx_empty,
      output full, level, ovf, err, tx_push, tx_wdata, st
   );

   modport master (
      output wr, wdata, flush, tx_empty,
      input  full, level, ovf, err, tx_push, tx_wdata, st
   );
endinterface

// File: rtl/lstx_feed_lsfifo.sv
// Circular word FIFO with wrapping pointers; a pop frees room for a same-cycle write.
module lsfifo
   import lstx_feed_pkg::*;
#(
   parameter int unsigned DMSB = DMSB_DEF,
   parameter int unsigned AMSB = AMSB_DEF
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            en,
   input  logic            wr,
   input  logic [DMSB:0]   wdata,
   input  logic            rd,
   input  logic            flush,
   output logic            full,
   output logic [AMSB+1:0] level,
   output logic [DMSB:0]   rdata
);
   localparam int unsigned AW    = AMSB + 1;
   localparam int unsigned LW    = AMSB + 2;
   localparam int unsigned DW    = DMSB + 1;
   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          do_wr, do_rd;

   always_comb begin
      full    = (level_q == LW'(DEPTH));
      do_rd   = en & ~flush & rd & (level_q != '0);
      do_wr   = en & ~flush & wr & (~full | do_rd);
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (en && flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         level_d = '0;
      end else begin
         if (do_wr) wptr_d = wptr_q + AW'(1);
         if (do_rd) rptr_d = rptr_q + AW'(1);
         level_d = level_q + LW'(do_wr) - LW'(do_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   // Storage carries no reset; validity is tracked by level alone.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wptr_q] <= wdata;
   end

   assign level = level_q;
   assign rdata = mem_q[rptr_q];

endmodule

// File: rtl/lstx_feed.sv
// Feeds buffered words to a toggle-handshake transmitter, with a busy watchdog.
module lstx_feed
   import lstx_feed_pkg::*;
#(
   parameter int unsigned DMSB = DMSB_DEF,
   parameter int unsigned AMSB = AMSB_DEF,
   parameter int unsigned TMSB = TMSB_DEF
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         setn,
   lstx_feed_if.slave   bus
);
   localparam int unsigned DW = DMSB + 1;
   localparam int unsigned LW = AMSB + 2;
   localparam int unsigned TW = TMSB + 1;
   localparam logic [TW-1:0] WDOG_LIMIT = '1;

   st_e           state_q, state_d;
   logic [TW-1:0] wdog_q, wdog_d, wdog_inc;
   logic          tx_push_q, tx_push_d;
   logic [DW-1:0] tx_wdata_q, tx_wdata_d;
   logic          ovf_q, ovf_d;
   logic          err_q, err_d;
   logic          issue;
   logic          fifo_full;
   logic [LW-1:0] fifo_level;
   logic [DW-1:0] fifo_rdata;

   lsfifo #(.DMSB(DMSB), .AMSB(AMSB)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .en    (setn),
      .wr    (bus.wr),
      .wdata (bus.wdata),
      .rd    (issue),
      .flush (bus.flush),
      .full  (fifo_full),
      .level (fifo_level),
      .rdata (fifo_rdata)
   );

   // The only pop: leaving idle with a word ready and the transmitter free.
   assign issue = setn && !bus.flush && (state_q == ST_IDLE) &&
                  (fifo_level != '0) && bus.tx_empty;

   always_comb begin
      state_d    = state_q;
      wdog_d     = wdog_q;
      tx_push_d  = tx_push_q;
      tx_wdata_d = tx_wdata_q;
      ovf_d      = ovf_q;
      err_d      = err_q;
      wdog_inc   = wdog_q + TW'(1);
      if (setn) begin
         if (bus.flush) begin
            ovf_d = 1'b0;
            err_d = 1'b0;
         end else if (bus.wr && fifo_full && !issue) begin
            ovf_d = 1'b1;
         end
         unique case (state_q)
            ST_IDLE: begin
               if (issue) begin
                  state_d    = ST_WBUSY;
                  tx_wdata_d = fifo_rdata;
                  tx_push_d  = ~tx_push_q;
                  wdog_d     = '0;
               end
            end
            ST_WBUSY: begin
               wdog_d = wdog_inc;
               if (!bus.tx_empty) begin
                  state_d = ST_WDONE;
               end else if (wdog_inc == WDOG_LIMIT) begin
                  state_d = ST_IDLE;
                  err_d   = ~bus.flush;
               end
            end
            ST_WDONE: begin
               if (bus.tx_empty) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         wdog_q     <= '0;
         tx_push_q  <= 1'b0;
         tx_wdata_q <= '0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wdog_q     <= wdog_d;
         tx_push_q  <= tx_push_d;
         tx_wdata_q <= tx_wdata_d;
         ovf_q      <= ovf_d;
         err_q      <= err_d;
      end
   end

   assign bus.full     = fifo_full;
   assign bus.level    = fifo_level;
   assign bus.ovf      = ovf_q;
   assign bus.err      = err_q;
   assign bus.tx_push  = tx_push_q;
   assign bus.tx_wdata = tx_wdata_q;
   assign bus.st       = state_q;

endmodule

// File: tb/tb_lstx_feed.sv
// Bench for lstx_feed: behavioural transmitter/receiver model plus word scoreboard.
module tb_lstx_feed;
   import lstx_feed_pkg::*;

   localparam int unsigned DMSB = 9;
   localparam int unsigned AMSB = 2;
   localparam int unsigned TMSB = 3;
   localparam int unsigned DW   = DMSB + 1;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic setn = 1'b0;

   logic model_en  = 1'b0;
   logic man_empty = 1'b1;
   logic model_empty;
   logic m_last;
   int   m_busy = 0;
   int   m_len  = 3;
   logic mon_last = 1'b0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   lstx_feed_if #(.DMSB(DMSB), .AMSB(AMSB)) bus ();

   lstx_feed #(.DMSB(DMSB), .AMSB(AMSB), .TMSB(TMSB)) dut (
      .clk  (clk),
      .rstn (rstn),
      .setn (setn),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   assign model_empty  = (m_busy == 0);
   assign bus.tx_empty = model_en ? model_empty : man_empty;

   // Transmitter model: each push toggle keeps it busy for m_len cycles.
   always @(posedge clk) begin
      if (!rstn) begin
         m_last <= 1'b0;
         m_busy <= 0;
      end else if (bus.tx_push !== m_last) begin
         m_last <= bus.tx_push;
         m_busy <= m_len;
      end else if (m_busy != 0) begin
         m_busy <= m_busy - 1;
      end
   end

   // Receiver side: every push toggle delivers the presented word.
   always @(negedge clk) begin
      if (!rstn) begin
         mon_last = 1'b0;
      end else if (bus.tx_push !== mon_last) begin
         got_q.push_back(bus.tx_wdata);
         mon_last = bus.tx_push;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rstn      = 1'b0;
      setn      = 1'b1;
      bus.wr    = 1'b0;
      bus.flush = 1'b0;
      tick(2);
      rstn = 1'b1;
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic drain(output bit ok);
      ok       = 1'b0;
      model_en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         tick(1);
         if (bus.level == '0 && bus.st == ST_IDLE && model_empty) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bus.wr    = 1'b1;
      bus.wdata = 10'h3C3;
      bus.flush = 1'b0;
      rstn      = 1'b0;
      setn      = 1'b0;
      tick(2);
      bus.wr = 1'b0;
      n_checks++; if (bus.st !== ST_IDLE) begin n_fail++; $display("FAIL reset_st: got %0d want 0", bus.st); end
      n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", bus.level); end
      n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.full); end
      n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
      n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
      n_checks++; if (bus.tx_push !== 1'b0) begin n_fail++; $display("FAIL reset_push: got %b want 0", bus.tx_push); end
      n_checks++; if (bus.tx_wdata !== 10'h000) begin n_fail++; $display("FAIL reset_wdata: got %h want 000", bus.tx_wdata); end
   endtask

   task automatic test_single();
      logic [7:0] seq;
      int         nseq;
      st_e        last;
      logic [DW-1:0] g;
      do_reset();
      model_en  = 1'b1;
      m_len     = 40;
      bus.wr    = 1'b1;
      bus.wdata = 10'h155;
      exp_q.push_back(10'h155);
      tick(1);
      bus.wr = 1'b0;
      n_checks++; if (bus.level !== 4'd1) begin n_fail++; $display("FAIL single_level_w: got %0d want 1", bus.level); end
      n_checks++; if (bus.tx_push !== 1'b0) begin n_fail++; $display("FAIL single_push_early: got %b want 0", bus.tx_push); end
      tick(1);
      n_checks++; if (bus.tx_push !== 1'b1) begin n_fail++; $display("FAIL single_push: got %b want 1", bus.tx_push); end
      n_checks++; if (bus.tx_wdata !== 10'h155) begin n_fail++; $display("FAIL single_wdata: got %h want 155", bus.tx_wdata); end
      n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL single_level_r: got %0d want 0", bus.level); end
      seq  = {2'b00, 2'b01, 4'b0};
      nseq = 2;
      last = bus.st;
      for (int c = 0; c < 200 && bus.st != ST_IDLE; c++) begin
         tick(1);
         if (bus.st != last) begin
            last = bus.st;
            if (nseq < 4) seq[7-2*nseq -: 2] = bus.st;
            nseq++;
         end
      end
      n_checks++;
      if (nseq !== 4 || seq !== 8'b00_01_10_00) begin
         n_fail++; $display("FAIL single_st_seq: got %b (%0d states) want 00011000 (4 states)", seq, nseq);
      end
      n_checks++;
      if (got_q.size() !== 1) begin n_fail++; $display("FAIL single_sb_count: got %0d want 1", got_q.size()); end
      if (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         n_checks++;
         if (g !== exp_q[0]) begin n_fail++; $display("FAIL single_sb_word: got %h want %h", g, exp_q[0]); end
      end
      m_len = 3;
   endtask

   task automatic test_overflow();
      logic [DW-1:0] w, g, e;
      bit ok;
      do_reset();
      model_en  = 1'b0;
      man_empty = 1'b0;
      for (int i = 0; i < 9; i++) begin
         w = DW'(i * 37 + 5);
         bus.wr    = 1'b1;
         bus.wdata = w;
         if (i < 8) exp_q.push_back(w);
         tick(1);
         if (i == 7) begin
            n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL ovf_full8: got %b want 1", bus.full); end
            n_checks++; if (bus.level !== 4'd8) begin n_fail++; $display("FAIL ovf_level8: got %0d want 8", bus.level); end
            n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", bus.ovf); end
         end
      end
      bus.wr = 1'b0;
      n_checks++; if (bus.level !== 4'd8) begin n_fail++; $display("FAIL ovf_level9: got %0d want 8", bus.level); end
      n_checks++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", bus.ovf); end
      drain(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_drain: got timeout want drained"); end
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ovf_sb_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if (g !== e) begin n_fail++; $display("FAIL ovf_sb_word: got %h want %h", g, e); end
      end
      n_checks++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", bus.ovf); end
      bus.flush = 1'b1;
      tick(1);
      bus.flush = 1'b0;
      n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_flush: got %b want 0", bus.ovf); end
   endtask

   task automatic test_simul();
      logic [DW-1:0] w[4];
      logic [DW-1:0] g, e;
      bit ok;
      do_reset();
      model_en  = 1'b0;
      man_empty = 1'b0;
      for (int i = 0; i < 4; i++) begin
         w[i]      = DW'($urandom_range(0, 1023));
         bus.wr    = 1'b1;
         bus.wdata = w[i];
         exp_q.push_back(w[i]);
         tick(1);
      end
      bus.wr = 1'b0;
      n_checks++; if (bus.level !== 4'd4) begin n_fail++; $display("FAIL simul_pre_level: got %0d want 4", bus.level); end
      bus.wr    = 1'b1;
      bus.wdata = 10'h2E1;
      exp_q.push_back(10'h2E1);
      man_empty = 1'b1;
      tick(1);
      bus.wr    = 1'b0;
      man_empty = 1'b0;
      n_checks++; if (bus.level !== 4'd4) begin n_fail++; $display("FAIL simul_level: got %0d want 4", bus.level); end
      n_checks++; if (bus.tx_wdata !== w[0]) begin n_fail++; $display("FAIL simul_wdata: got %h want %h", bus.tx_wdata, w[0]); end
      n_checks++; if (bus.st !== ST_WBUSY) begin n_fail++; $display("FAIL simul_st: got %0d want 1", bus.st); end
      // Refill to full, then pop and write on the same edge.
      for (int i = 0; i < 4; i++) begin
         bus.wr    = 1'b1;
         bus.wdata = DW'(10'h040 + i);
         exp_q.push_back(DW'(10'h040 + i));
         tick(1);
      end
      bus.wr    = 1'b0;
      man_empty = 1'b1;
      tick(1);
      n_checks++; if (bus.full !== 1'b1 || bus.st !== ST_IDLE) begin n_fail++; $display("FAIL fullpop_pre: got full=%b st=%0d want full=1 st=0", bus.full, bus.st); end
      bus.wr    = 1'b1;
      bus.wdata = 10'h3F0;
      exp_q.push_back(10'h3F0);
      tick(1);
      bus.wr    = 1'b0;
      man_empty = 1'b0;
      n_checks++; if (bus.level !== 4'd8) begin n_fail++; $display("FAIL fullpop_level: got %0d want 8", bus.level); end
      n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf: got %b want 0", bus.ovf); end
      n_checks++; if (bus.tx_wdata !== w[1]) begin n_fail++; $display("FAIL fullpop_wdata: got %h want %h", bus.tx_wdata, w[1]); end
      drain(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL simul_drain: got timeout want drained"); end
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL simul_sb_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if (g !== e) begin n_fail++; $display("FAIL simul_sb_word: got %h want %h", g, e); end
      end
   endtask

   task automatic test_watchdog();
      do_reset();
      model_en  = 1'b0;
      man_empty = 1'b1;
      bus.wr    = 1'b1;
      bus.wdata = 10'h0A5;
      tick(1);
      bus.wr = 1'b0;
      tick(1);
      n_checks++; if (bus.st !== ST_WBUSY) begin n_fail++; $display("FAIL wdog_issue: got %0d want 1", bus.st); end
      n_checks++; if (bus.tx_wdata !== 10'h0A5) begin n_fail++; $display("FAIL wdog_wdata: got %h want 0a5", bus.tx_wdata); end
      tick(14);
      n_checks++; if (bus.st !== ST_WBUSY || bus.err !== 1'b0) begin n_fail++; $display("FAIL wdog_early: got st=%0d err=%b want st=1 err=0", bus.st, bus.err); end
      tick(1);
      n_checks++; if (bus.st !== ST_IDLE) begin n_fail++; $display("FAIL wdog_st: got %0d want 0", bus.st); end
      n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL wdog_err: got %b want 1", bus.err); end
      bus.flush = 1'b1;
      tick(1);
      bus.flush = 1'b0;
      n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL wdog_flush: got %b want 0", bus.err); end
   endtask

   task automatic test_flush_wdone();
      logic push_save;
      do_reset();
      model_en  = 1'b0;
      man_empty = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.wr    = 1'b1;
         bus.wdata = DW'(10'h100 + i);
         tick(1);
      end
      bus.wr    = 1'b0;
      man_empty = 1'b1;
      tick(1);
      man_empty = 1'b0;
      tick(1);
      n_checks++; if (bus.st !== ST_WDONE || bus.level !== 4'd5) begin n_fail++; $display("FAIL fl_pre: got st=%0d level=%0d want st=2 level=5", bus.st, bus.level); end
      n_checks++; if (bus.tx_wdata !== 10'h100) begin n_fail++; $display("FAIL fl_wdata: got %h want 100", bus.tx_wdata); end
      push_save = bus.tx_push;
      bus.flush = 1'b1;
      tick(1);
      bus.flush = 1'b0;
      n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL fl_level: got %0d want 0", bus.level); end
      n_checks++; if (bus.st !== ST_WDONE) begin n_fail++; $display("FAIL fl_st_wait: got %0d want 2", bus.st); end
      man_empty = 1'b1;
      tick(1);
      n_checks++; if (bus.st !== ST_IDLE) begin n_fail++; $display("FAIL fl_st_idle: got %0d want 0", bus.st); end
      tick(5);
      n_checks++; if (bus.tx_push !== push_save || bus.st !== ST_IDLE) begin n_fail++; $display("FAIL fl_no_toggle: got push=%b st=%0d want push=%b st=0", bus.tx_push, bus.st, push_save); end
   endtask

   task automatic test_setn();
      do_reset();
      model_en  = 1'b0;
      man_empty = 1'b0;
      setn      = 1'b0;
      bus.wr    = 1'b1;
      bus.wdata = 10'h1C7;
      tick(1);
      n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL setn_wr_hold: got %0d want 0", bus.level); end
      setn = 1'b1;
      tick(1);
      bus.wr = 1'b0;
      n_checks++; if (bus.level !== 4'd1) begin n_fail++; $display("FAIL setn_wr: got %0d want 1", bus.level); end
      setn      = 1'b0;
      man_empty = 1'b1;
      tick(2);
      n_checks++; if (bus.tx_push !== 1'b0 || bus.st !== ST_IDLE || bus.level !== 4'd1) begin n_fail++; $display("FAIL setn_issue_hold: got push=%b st=%0d level=%0d want 0 0 1", bus.tx_push, bus.st, bus.level); end
      bus.flush = 1'b1;
      tick(1);
      bus.flush = 1'b0;
      n_checks++; if (bus.level !== 4'd1) begin n_fail++; $display("FAIL setn_flush_hold: got %0d want 1", bus.level); end
      setn = 1'b1;
      tick(1);
      n_checks++; if (bus.tx_push !== 1'b1 || bus.tx_wdata !== 10'h1C7) begin n_fail++; $display("FAIL setn_resume: got push=%b wdata=%h want 1 1c7", bus.tx_push, bus.tx_wdata); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      model_en  = 1'b0;
      man_empty = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.wr    = 1'b1;
         bus.wdata = DW'(10'h2A0 + i);
         tick(1);
      end
      bus.wr    = 1'b0;
      man_empty = 1'b1;
      tick(1);
      man_empty = 1'b0;
      n_checks++; if (bus.tx_push !== 1'b1) begin n_fail++; $display("FAIL rmid_issue: got %b want 1", bus.tx_push); end
      rstn = 1'b0;
      tick(1);
      rstn = 1'b1;
      n_checks++; if (bus.st !== ST_IDLE || bus.level !== 4'd0) begin n_fail++; $display("FAIL rmid_state: got st=%0d level=%0d want 0 0", bus.st, bus.level); end
      n_checks++; if (bus.tx_push !== 1'b0 || bus.tx_wdata !== 10'h000) begin n_fail++; $display("FAIL rmid_tx: got push=%b wdata=%h want 0 000", bus.tx_push, bus.tx_wdata); end
      man_empty = 1'b1;
      tick(10);
      n_checks++; if (bus.tx_push !== 1'b0 || bus.st !== ST_IDLE) begin n_fail++; $display("FAIL rmid_quiet: got push=%b st=%0d want 0 0", bus.tx_push, bus.st); end
   endtask

   task automatic test_loopback();
      logic [DW-1:0] words[4];
      logic [DW-1:0] g, e;
      bit ok;
      words = '{10'h000, 10'h3FF, 10'h2AA, 10'h155};
      do_reset();
      model_en = 1'b1;
      m_len    = 12;
      for (int i = 0; i < 4; i++) begin
         bus.wr    = 1'b1;
         bus.wdata = words[i];
         exp_q.push_back(words[i]);
         tick(1);
      end
      bus.wr = 1'b0;
      drain(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL loop_drain: got timeout want drained"); end
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL loop_sb_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if (g !== e) begin n_fail++; $display("FAIL loop_sb_word: got %h want %h", g, e); end
      end
      n_checks++; if (bus.ovf !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL loop_flags: got ovf=%b err=%b want 0 0", bus.ovf, bus.err); end
      m_len = 3;
   endtask

   initial begin
      bus.wr    = 1'b0;
      bus.wdata = '0;
      bus.flush = 1'b0;
      test_reset();
      test_single();
      test_overflow();
      test_simul();
      test_watchdog();
      test_flush_wdone();
      test_setn();
      test_reset_mid();
      test_loopback();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish want finish before limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/lstx_feed.md
LSTX_FEED -- requirements
Module: lstx_feed

Interface
REQ-001 Parameter DMSB, default 9: word MSB, equal to the DMSB of the downstream transmitter.
REQ-002 Parameter AMSB, default 2: FIFO address MSB; depth = 2^(AMSB+1) = 8.
REQ-003 Parameter TMSB, default 3: busy-watchdog counter MSB; limit = 2^(TMSB+1)-1 = 15 cycles.
REQ-004 Port clk  in  1: single clock; all state updates on posedge clk.
REQ-005 Port rstn  in  1: reset, synchronous, active-low.
REQ-006 Port setn  in  1: clock enable; when low, all state holds (reset still wins).
REQ-007 Port wr  in  1: level strobe; one word written per cycle while high.
REQ-008 Port wdata  in  DMSB+1: write word, sampled when wr=1.
REQ-009 Port flush  in  1: level strobe; empties FIFO and clears sticky flags.
REQ-010 Port full  out  1: FIFO holds depth words.
REQ-011 Port level  out  AMSB+2: number of stored words, 0..depth.
REQ-012 Port ovf  out  1: sticky; a write was dropped because the FIFO was full.
REQ-013 Port err  out  1: sticky; watchdog expired in ST_WBUSY.
REQ-014 Port tx_push  out  1: toggle request to the transmitter; each level change is one word.
REQ-015 Port tx_wdata  out  DMSB+1: registered word presented to the transmitter.
REQ-016 Port tx_empty  in  1: transmitter idle flag.
REQ-017 Port st  out  2: current FSM state.

Function
REQ-018 The FIFO is circular, with wrapping pointers and level = stored count.
REQ-019 Write: wr=1 and not full stores wdata at the write pointer.
REQ-020 Write: wr=1 and full drops the word and sets ovf.
REQ-021 Issue: a read is popped only by the ST_IDLE->ST_WBUSY transition.
REQ-022 Same-cycle write and pop, including when full: both occur and level is unchanged.
REQ-023 FSM states: ST_IDLE=2'b00, ST_WBUSY=2'b01, ST_WDONE=2'b10.
REQ-024 ST_IDLE->ST_WBUSY when level!=0 and tx_empty=1, with these same-edge effects:
  - tx_wdata <= FIFO head;
  - tx_push <= ~tx_push;
  - read pointer advances;
  - watchdog <= 0.
REQ-025 ST_WBUSY->ST_WDONE when tx_empty=0.
REQ-026 ST_WBUSY->ST_IDLE with err set when the watchdog reaches the limit before tx_empty=0; otherwise the watchdog increments each cycle.
REQ-027 ST_WDONE->ST_IDLE when tx_empty=1.
REQ-028 tx_wdata and tx_push are stable outside the issue edge.
REQ-029 Latency: word written into an empty FIFO at edge N with tx_empty=1 -> tx_push toggles at edge N+1.
REQ-030 flush priority: flush=1 resets both pointers and level to 0, clears ovf and err, and suppresses any same-cycle write and issue.
REQ-031 flush does not touch the FSM; a word already issued completes normally.
REQ-032 setn=0 freezes the FIFO, FSM, watchdog and outputs, and inputs are ignored that cycle.

Reset
REQ-033 rstn=0 at posedge clk sets pointers, level, ovf, err, watchdog, tx_push and tx_wdata to 0 and st to ST_IDLE, regardless of setn.
REQ-034 Reset mid-transfer returns the block to ST_IDLE with the FIFO empty; no further tx_push toggle occurs until a new write.

Structure
REQ-035 State encodings and parameter defaults live in the shared lsrt include file, next to the transmitter/receiver state constants.
REQ-036 FIFO storage and pointers form one sub-module, lsfifo (ports: wr, wdata, rd, flush, full, level, rdata); the FSM, watchdog and toggle logic stay in lstx_feed.

Verification
REQ-037 Reset, then write 0x155 with tx_empty=1:
  - tx_push 0->1 one cycle after the write edge, tx_wdata=0x155, level back to 0;
  - tx_empty model low for 40 cycles then high -> st sequence 00->01->10->00.
REQ-038 Write 9 words with tx_empty=0 held:
  - full=1 after 8, level=8;
  - 9th dropped, ovf=1.
REQ-039 level=4, simultaneous wr and issue -> level stays 4, tx_wdata = oldest word.
REQ-040 tx_empty held 1 after an issue -> after 15 cycles st=00 and err=1; flush -> err=0.
REQ-041 flush during ST_WDONE with level=5:
  - level=0 next cycle;
  - FSM still waits for tx_empty=1, then stays ST_IDLE with no further toggle.
REQ-042 End-to-end: connect to the transmitter and a receiver in loopback, stream 0x000, 0x3FF, 0x2AA, 0x155 -> received in order, no ovf or err.
